imem_loader: RTL

- Writer-side counterpart of the instruction memory read path.
- Receives a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory at consecutive word indices (index 0 = byte address BASE_ADDR).
- Holds the CPU in reset until the program is loaded and its checksum verified.

---
 rtl/imem_loader.sv | 119 +++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream, writes little-endian 32-bit words into
// instruction memory and holds the CPU in reset until the checksum is verified.
module imem_loader #(
    parameter int          ADDR_W    = 11,
    parameter logic [31:0] BASE_ADDR = 32'h00400000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_waddr,
    output logic [31:0]       im_wdata,
    output logic [31:0]       im_baddr,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_cnt
);
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERR} state_t;

    state_t            state_q;
    logic [15:0]       len_q;
    logic [31:0]       word_q;
    logic [7:0]        csum_q;
    logic [1:0]        idx_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W:0]   cnt_q;
    logic              hold_q;
    logic              done_q;
    logic              err_q;
    logic              xfer;
    logic [15:0]       len_d;
    logic [15:0]       cnt_d;

    assign byte_ready = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                        (state_q == DATA)   || (state_q == CHECK);
    assign xfer       = byte_valid && byte_ready;
    assign len_d      = {byte_data, len_q[7:0]};
    assign cnt_d      = 16'(cnt_q) + 16'd1;
    assign im_we      = (state_q == WRITE);
    assign im_waddr   = waddr_q;
    assign im_wdata   = wdata_q;
    assign im_baddr   = BASE_ADDR + {{(30-ADDR_W){1'b0}}, waddr_q, 2'b00};
    assign cpu_hold   = hold_q;
    assign done       = done_q;
    assign err        = err_q;
    assign word_cnt   = cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            len_q   <= '0;
            word_q  <= '0;
            csum_q  <= '0;
            idx_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE, ERR: if (start) begin
                    state_q <= LEN_LO;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    cnt_q   <= '0;
                    csum_q  <= '0;
                    idx_q   <= '0;
                    hold_q  <= 1'b1;
                end
                LEN_LO: if (xfer) begin
                    len_q[7:0] <= byte_data;
                    state_q    <= LEN_HI;
                end
                LEN_HI: if (xfer) begin
                    len_q[15:8] <= byte_data;
                    if (32'(len_d) > (32'd1 << ADDR_W)) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end else begin
                        state_q <= (len_d == 16'd0) ? CHECK : DATA;
                    end
                end
                DATA: if (xfer) begin
                    word_q[{idx_q, 3'b000} +: 8] <= byte_data;
                    csum_q <= csum_q ^ byte_data;
                    idx_q  <= idx_q + 2'd1;
                    // Lane 3 completes the word: latch it for the write cycle that follows.
                    if (idx_q == 2'd3) begin
                        wdata_q <= {byte_data, word_q[23:0]};
                        waddr_q <= cnt_q[ADDR_W-1:0];
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    cnt_q   <= cnt_q + 1'b1;
                    state_q <= (cnt_d == len_q) ? CHECK : DATA;
                end
                CHECK: if (xfer) begin
                    if (byte_data == csum_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        hold_q  <= 1'b0;
                    end else begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
